// File: rtl/ml_ahb_pkg.sv
// Shared AHB-Lite constants and control-bundle types for the multi-layer matrix.
// The slave port mux reuses the control bundle layout and width defined here.
package ml_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // htrans + hwrite + hsize + hburst + hprot, i.e. everything but the address
    localparam int CTRL_NONADDR_WIDTH = 2 + 1 + 3 + 3 + 4;

    function automatic int ctrl_width(input int addr_width);
        return addr_width + CTRL_NONADDR_WIDTH;
    endfunction

    localparam int ML_AHB_ADDR_WIDTH = 32;
    localparam int ML_AHB_CTRL_WIDTH = ctrl_width(ML_AHB_ADDR_WIDTH);

    typedef struct packed {
        logic [1:0] htrans;
        logic       hwrite;
        logic [2:0] hsize;
        logic [2:0] hburst;
        logic [3:0] hprot;
    } ahb_ctrl_t;

    // A held transfer must re-arbitrate as NONSEQ; INCR keeps later master SEQs legal.
    function automatic ahb_ctrl_t reissue_ctrl(input ahb_ctrl_t c);
        ahb_ctrl_t r;
        r = c;
        if (c.htrans == HTRANS_SEQ) begin
            r.htrans = HTRANS_NONSEQ;
            r.hburst = HBURST_INCR;
        end
        return r;
    endfunction

    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ml_ahb_mst_in_stage_if.sv
// Bus bundle between one AHB-Lite master, its input stage and the slave-port arbiter/mux.
// The stage uses the slave modport; the master/arbiter environment uses the master modport.
interface ml_ahb_mst_in_stage_if
    import ml_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] m_haddr;
    logic [1:0]            m_htrans;
    logic                  m_hwrite;
    logic [2:0]            m_hsize;
    logic [2:0]            m_hburst;
    logic [3:0]            m_hprot;
    logic                  m_hready_out;
    logic                  m_hresp;

    logic [ADDR_WIDTH-1:0] s_haddr;
    logic [1:0]            s_htrans;
    logic                  s_hwrite;
    logic [2:0]            s_hsize;
    logic [2:0]            s_hburst;
    logic [3:0]            s_hprot;
    logic                  s_sel;
    logic                  s_htrans0;
    logic                  s_grant;
    logic                  s_hready;
    logic                  s_hresp;

    modport slave (
        input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot,
        output m_hready_out, m_hresp,
        output s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot,
        output s_sel, s_htrans0,
        input  s_grant, s_hready, s_hresp
    );

    modport master (
        output m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot,
        input  m_hready_out, m_hresp,
        input  s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot,
        input  s_sel, s_htrans0,
        output s_grant, s_hready, s_hresp
    );

endinterface

// File: rtl/ml_ahb_mst_in_stage.sv
// Master-side input stage: forwards address/control live when granted, otherwise
// parks the transfer in a holding register and stalls the master until it completes.
module ml_ahb_mst_in_stage
    import ml_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        hclk,
    input  logic                        resetn,
    ml_ahb_mst_in_stage_if.slave        bus
);

    logic                  hold_valid;
    logic                  hold_valid_next;
    logic                  dphase_act;
    logic                  dphase_act_next;
    logic [ADDR_WIDTH-1:0] hold_addr;
    ahb_ctrl_t             hold_ctrl;
    ahb_ctrl_t             live_ctrl;
    ahb_ctrl_t             out_ctrl;
    logic                  hready_int;
    logic                  accept;
    logic                  capture;

    always_comb begin
        live_ctrl        = '0;
        live_ctrl.htrans = bus.m_htrans;
        live_ctrl.hwrite = bus.m_hwrite;
        live_ctrl.hsize  = bus.m_hsize;
        live_ctrl.hburst = bus.m_hburst;
        live_ctrl.hprot  = bus.m_hprot;
    end

    // Zero-latency pass-through unless a parked transfer owns the request.
    always_comb begin
        out_ctrl      = hold_valid ? hold_ctrl : live_ctrl;
        bus.s_haddr   = hold_valid ? hold_addr : bus.m_haddr;
        bus.s_htrans  = out_ctrl.htrans;
        bus.s_hwrite  = out_ctrl.hwrite;
        bus.s_hsize   = out_ctrl.hsize;
        bus.s_hburst  = out_ctrl.hburst;
        bus.s_hprot   = out_ctrl.hprot;
        bus.s_sel     = is_active(out_ctrl.htrans);
        bus.s_htrans0 = out_ctrl.htrans[0];
    end

    always_comb begin
        hready_int = 1'b1;
        if (hold_valid) begin
            hready_int = 1'b0;
        end else if (dphase_act) begin
            hready_int = bus.s_hready;
        end
        bus.m_hready_out = hready_int;
        bus.m_hresp      = dphase_act ? bus.s_hresp : HRESP_OKAY;
    end

    // Capture excludes accept, so a parked transfer can never be loaded and released together.
    assign accept  = is_active(out_ctrl.htrans) & bus.s_grant & bus.s_hready;
    assign capture = ~hold_valid & hready_int & is_active(live_ctrl.htrans) & ~accept;

    always_comb begin
        hold_valid_next = hold_valid;
        dphase_act_next = dphase_act;
        if (capture) begin
            hold_valid_next = 1'b1;
        end else if (hold_valid && accept) begin
            hold_valid_next = 1'b0;
        end
        if (accept) begin
            dphase_act_next = 1'b1;
        end else if (bus.s_hready) begin
            dphase_act_next = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            hold_valid <= 1'b0;
            dphase_act <= 1'b0;
        end else begin
            hold_valid <= hold_valid_next;
            dphase_act <= dphase_act_next;
        end
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            hold_addr <= '0;
            hold_ctrl <= '0;
        end else if (capture) begin
            hold_addr <= bus.m_haddr;
            hold_ctrl <= reissue_ctrl(live_ctrl);
        end
    end

endmodule
